// File: rtl/core_run_ctrl.sv
// Run controller for the single-cycle RISC-V core: streams a program into
// instruction memory, releases the core, then watches for the pass signature.
module core_run_ctrl #(
    parameter int          IMEM_DEPTH = 64,
    parameter int          AW         = 6,
    parameter logic [31:0] PASS_ADDR  = 32'd100,
    parameter logic [31:0] PASS_DATA  = 32'd25,
    parameter int          TIMEOUT    = 200
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          load_valid,
    input  logic [31:0]   load_data,
    input  logic          load_last,
    output logic          load_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          core_rst_n,
    output logic          core_en,
    input  logic          memwrite,
    input  logic [31:0]   dataadr,
    input  logic [31:0]   writedata,
    output logic          done,
    output logic          pass,
    output logic          fail,
    output logic          timeout,
    output logic [15:0]   cycle_count
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [AW-1:0] LAST_ADDR    = AW'(IMEM_DEPTH - 1);
    localparam logic [15:0]   TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_t        state, state_d;
    logic [AW-1:0] ptr, ptr_d;
    logic          load_ready_d, imem_we_d, core_rst_n_d, core_en_d;
    logic [AW-1:0] imem_addr_d;
    logic [31:0]   imem_wdata_d;
    logic          done_d, pass_d, fail_d, timeout_d;
    logic [15:0]   cycle_count_d;

    logic accept;
    logic sig_hit;

    assign accept  = load_valid && load_ready;
    assign sig_hit = memwrite && (dataadr == PASS_ADDR);

    always_comb begin
        // NOTE: every next-value gets a default first, so no branch can infer a latch.
        state_d       = state;
        ptr_d         = ptr;
        load_ready_d  = load_ready;
        imem_we_d     = 1'b0;
        imem_addr_d   = imem_addr;
        imem_wdata_d  = imem_wdata;
        core_rst_n_d  = core_rst_n;
        core_en_d     = core_en;
        done_d        = done;
        pass_d        = pass;
        fail_d        = fail;
        timeout_d     = timeout;
        cycle_count_d = cycle_count;

        unique case (state)
            IDLE: begin
                core_rst_n_d = 1'b0;
                core_en_d    = 1'b0;
                if (start) begin
                    state_d      = LOAD;
                    ptr_d        = '0;
                    load_ready_d = 1'b1;
                end
            end

            LOAD: begin
                if (accept) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = ptr;
                    imem_wdata_d = load_data;
                    ptr_d        = ptr + AW'(1);
                    // The final write is issued on the same edge the core is released.
                    if (load_last || (ptr == LAST_ADDR)) begin
                        state_d       = RUN;
                        load_ready_d  = 1'b0;
                        core_rst_n_d  = 1'b1;
                        core_en_d     = 1'b1;
                        cycle_count_d = '0;
                    end
                end
            end

            RUN: begin
                if (sig_hit) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    core_en_d = 1'b0;
                    pass_d    = (writedata == PASS_DATA);
                    fail_d    = (writedata != PASS_DATA);
                end else if (cycle_count == TIMEOUT_LAST) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    core_en_d = 1'b0;
                    fail_d    = 1'b1;
                    timeout_d = 1'b1;
                end else if (cycle_count != 16'hFFFF) begin
                    cycle_count_d = cycle_count + 16'd1;
                end
            end

            DONE: begin
                // Core stays out of reset but frozen so its state can be inspected.
                if (start) begin
                    state_d       = LOAD;
                    ptr_d         = '0;
                    load_ready_d  = 1'b1;
                    core_rst_n_d  = 1'b0;
                    core_en_d     = 1'b0;
                    done_d        = 1'b0;
                    pass_d        = 1'b0;
                    fail_d        = 1'b0;
                    timeout_d     = 1'b0;
                    cycle_count_d = '0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register sees pre-edge values.
        if (!rst_n || abort) begin
            state       <= IDLE;
            ptr         <= '0;
            load_ready  <= 1'b0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            core_rst_n  <= 1'b0;
            core_en     <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
        end else begin
            state       <= state_d;
            ptr         <= ptr_d;
            load_ready  <= load_ready_d;
            imem_we     <= imem_we_d;
            imem_addr   <= imem_addr_d;
            imem_wdata  <= imem_wdata_d;
            core_rst_n  <= core_rst_n_d;
            core_en     <= core_en_d;
            done        <= done_d;
            pass        <= pass_d;
            fail        <= fail_d;
            timeout     <= timeout_d;
            cycle_count <= cycle_count_d;
        end
    end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Self-checking bench for core_run_ctrl: a phase/verdict model checked every
// cycle, plus directed load/run scenarios with literal expectations.
module tb_core_run_ctrl;

    localparam int          IMEM_DEPTH = 64;
    localparam int          AW         = 6;
    localparam int          TIMEOUT    = 200;
    localparam logic [31:0] PASS_ADDR  = 32'd100;
    localparam logic [31:0] PASS_DATA  = 32'd25;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic          load_valid = 1'b0, load_last = 1'b0, memwrite = 1'b0;
    logic [31:0]   load_data = '0, dataadr = '0, writedata = '0;
    logic          load_ready, imem_we, core_rst_n, core_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          done, pass, fail, timeout;
    logic [15:0]   cycle_count;

    core_run_ctrl #(
        .IMEM_DEPTH(IMEM_DEPTH), .AW(AW), .PASS_ADDR(PASS_ADDR),
        .PASS_DATA(PASS_DATA), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_rst_n(core_rst_n), .core_en(core_en),
        .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input int i);
        return 32'h0010_0093 + (32'(i) << 7);
    endfunction

    // Model: what phase the run is in, what verdict it reached, how far it got.
    typedef enum {PH_IDLE, PH_LOAD, PH_RUN, PH_DONE} phase_t;
    typedef enum {V_NONE, V_PASS, V_FAIL, V_TIMEOUT} verdict_t;

    phase_t      ph = PH_IDLE;
    verdict_t    verdict = V_NONE;
    int          words = 0;
    int          run_len = 0;
    bit          wr_pending = 1'b0;
    int          wr_addr = 0;
    logic [31:0] wr_data = '0;

    always @(posedge clk) begin
        if (!rst_n || abort) begin
            ph         <= PH_IDLE;
            verdict    <= V_NONE;
            words      <= 0;
            run_len    <= 0;
            wr_pending <= 1'b0;
            wr_addr    <= 0;
            wr_data    <= '0;
        end else begin
            wr_pending <= 1'b0;
            case (ph)
                PH_IDLE, PH_DONE: if (start) begin
                    ph      <= PH_LOAD;
                    words   <= 0;
                    verdict <= V_NONE;
                    run_len <= 0;
                end
                PH_LOAD: if (load_valid) begin
                    wr_pending <= 1'b1;
                    wr_addr    <= words;
                    wr_data    <= load_data;
                    words      <= words + 1;
                    if (load_last || words == IMEM_DEPTH - 1) begin
                        ph      <= PH_RUN;
                        run_len <= 0;
                    end
                end
                PH_RUN: begin
                    if (memwrite && dataadr == PASS_ADDR) begin
                        verdict <= (writedata == PASS_DATA) ? V_PASS : V_FAIL;
                        ph      <= PH_DONE;
                    end else if (run_len == TIMEOUT - 1) begin
                        verdict <= V_TIMEOUT;
                        ph      <= PH_DONE;
                    end else begin
                        run_len <= run_len + 1;
                    end
                end
                default: ;
            endcase
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("load_ready",  32'(load_ready),  32'(ph == PH_LOAD));
            check("core_en",     32'(core_en),     32'(ph == PH_RUN));
            check("core_rst_n",  32'(core_rst_n),  32'(ph == PH_RUN || ph == PH_DONE));
            check("done",        32'(done),        32'(ph == PH_DONE));
            check("pass",        32'(pass),        32'(verdict == V_PASS));
            check("fail",        32'(fail),        32'(verdict == V_FAIL || verdict == V_TIMEOUT));
            check("timeout",     32'(timeout),     32'(verdict == V_TIMEOUT));
            check("cycle_count", 32'(cycle_count), 32'(run_len));
            check("imem_we",     32'(imem_we),     32'(wr_pending));
            check("imem_addr",   32'(imem_addr),   32'(wr_addr));
            check("imem_wdata",  imem_wdata,       wr_data);
        end
    end

    // Log of every instruction-memory write the DUT issues.
    logic [AW-1:0] log_addr [0:255];
    logic [31:0]   log_data [0:255];
    int            wr_total = 0;

    always @(posedge clk) begin
        #1;
        if (imem_we && wr_total < 256) begin
            log_addr[wr_total] <= imem_addr;
            log_data[wr_total] <= imem_wdata;
            wr_total           <= wr_total + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_load();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last);
        int waited = 0;
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        while (!load_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("load_ready_wait", 32'(load_ready), 32'd1);
        @(negedge clk);
    endtask

    // Returns at the negedge right after the final acceptance edge.
    task automatic load_prog(input int n, input bit use_last, input int base);
        for (int i = 0; i < n; i++)
            send_word(word_of(base + i), use_last && (i == n - 1));
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = d;
        @(negedge clk);
        memwrite  = 1'b0;
        dataadr   = '0;
        writedata = '0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_core_rst_n"},  32'(core_rst_n),  32'd0);
        check({tag, "_core_en"},     32'(core_en),     32'd0);
        check({tag, "_imem_we"},     32'(imem_we),     32'd0);
        check({tag, "_load_ready"},  32'(load_ready),  32'd0);
        check({tag, "_done"},        32'(done),        32'd0);
        check({tag, "_flags"},       32'({pass, fail, timeout}), 32'd0);
        check({tag, "_cycle_count"}, 32'(cycle_count), 32'd0);
        check({tag, "_imem_addr"},   32'(imem_addr),   32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base;

        rst_n = 1'b0;
        tick(2);
        chk_en = 1'b1;
        check_cleared("reset");
        rst_n = 1'b1;
        tick(1);

        // 18-word program ended by load_last, then a pass store at cycle 40.
        base = wr_total;
        start_load();
        load_prog(18, 1'b1, 0);
        check("t1_run_core_rst_n", 32'(core_rst_n), 32'd1);
        check("t1_run_core_en",    32'(core_en),    32'd1);
        check("t1_final_we",       32'(imem_we),    32'd1);
        check("t1_final_addr",     32'(imem_addr),  32'd17);
        check("t1_load_ready",     32'(load_ready), 32'd0);
        check("t1_write_count",    32'(wr_total - base), 32'd18);
        for (int i = 0; i < 18; i++) begin
            check("t1_log_addr", 32'(log_addr[base + i]), 32'(i));
            check("t1_log_data", log_data[base + i], word_of(i));
        end
        tick(40);
        store(32'd100, 32'd25);
        check("t1_pass",        32'(pass),        32'd1);
        check("t1_done",        32'(done),        32'd1);
        check("t1_fail",        32'(fail),        32'd0);
        check("t1_cycle_count", 32'(cycle_count), 32'd40);
        check("t1_core_en",     32'(core_en),     32'd0);
        check("t1_core_rst_n",  32'(core_rst_n),  32'd1);
        tick(3);
        check("t1_hold_count",  32'(cycle_count), 32'd40);

        // Wrong data at the pass address; an earlier store elsewhere is ignored.
        start_load();
        load_prog(4, 1'b1, 100);
        tick(5);
        store(32'd96, 32'd25);
        check("t2_ignored_done", 32'(done),    32'd0);
        check("t2_still_run",    32'(core_en), 32'd1);
        tick(4);
        store(32'd100, 32'd7);
        check("t2_fail",        32'(fail),        32'd1);
        check("t2_timeout",     32'(timeout),     32'd0);
        check("t2_done",        32'(done),        32'd1);
        check("t2_pass",        32'(pass),        32'd0);
        check("t2_cycle_count", 32'(cycle_count), 32'd10);

        // No signature: timeout on cycle 199.
        start_load();
        load_prog(4, 1'b1, 200);
        tick(205);
        check("t3_timeout",     32'(timeout),     32'd1);
        check("t3_fail",        32'(fail),        32'd1);
        check("t3_done",        32'(done),        32'd1);
        check("t3_pass",        32'(pass),        32'd0);
        check("t3_cycle_count", 32'(cycle_count), 32'd199);

        // Pass store on exactly the timeout cycle: the match wins.
        start_load();
        load_prog(4, 1'b1, 300);
        tick(199);
        store(32'd100, 32'd25);
        check("t3b_pass",        32'(pass),        32'd1);
        check("t3b_timeout",     32'(timeout),     32'd0);
        check("t3b_fail",        32'(fail),        32'd0);
        check("t3b_cycle_count", 32'(cycle_count), 32'd199);

        // Full 64-word image with no load_last; a 65th word is never taken.
        base = wr_total;
        start_load();
        load_prog(64, 1'b0, 400);
        load_valid = 1'b1;
        load_data  = word_of(999);
        tick(5);
        load_valid = 1'b0;
        check("t4_write_count", 32'(wr_total - base),      32'd64);
        check("t4_last_addr",   32'(log_addr[base + 63]),  32'd63);
        check("t4_last_data",   log_data[base + 63],       word_of(463));
        check("t4_load_ready",  32'(load_ready),           32'd0);
        check("t4_running",     32'(core_en),              32'd1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check_cleared("t4_abort");

        // Abort right after word 5, then reload from address 0.
        start_load();
        load_prog(5, 1'b0, 500);
        check("t5_inflight_we", 32'(imem_we), 32'd1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check_cleared("t5_abort");
        tick(2);
        check("t5_idle_ready", 32'(load_ready), 32'd0);
        base = wr_total;
        start_load();
        load_prog(3, 1'b1, 600);
        check("t5_reload_addr0", 32'(log_addr[base]),     32'd0);
        check("t5_reload_addr2", 32'(log_addr[base + 2]), 32'd2);
        check("t5_reload_data0", log_data[base],          word_of(600));

        // Synchronous reset in the middle of a run, then reload.
        tick(10);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check_cleared("t6_reset");
        base = wr_total;
        start_load();
        load_prog(2, 1'b1, 700);
        check("t6_reload_addr0", 32'(log_addr[base]),     32'd0);
        check("t6_reload_addr1", 32'(log_addr[base + 1]), 32'd1);
        check("t6_reload_data1", log_data[base + 1],      word_of(701));
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
